// File: rtl/mult4_share_pkg.sv
// Shared types and constants for the time-shared 4x4 multiplier controller.
package mult4_share_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester index width; a single requester bit is kept even for NREQ<=2.
  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Multi4.sv
// 4x4 unsigned combinational array multiplier with bit-level ports.
module Multi4 (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic m0,
  output logic m1,
  output logic m2,
  output logic m3,
  output logic m4,
  output logic m5,
  output logic m6,
  output logic m7
);

  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] sum;

  assign a = {a3, a2, a1, a0};
  assign b = {b3, b2, b1, b0};

  // One partial-product row per multiplier bit, each shifted to its weight.
  assign pp0 = {4'b0000, a & {4{b[0]}}};
  assign pp1 = {3'b000,  a & {4{b[1]}}, 1'b0};
  assign pp2 = {2'b00,   a & {4{b[2]}}, 2'b00};
  assign pp3 = {1'b0,    a & {4{b[3]}}, 3'b000};
  assign sum = pp0 + pp1 + pp2 + pp3;

  assign {m7, m6, m5, m4, m3, m2, m1, m0} = sum;

endmodule

// File: rtl/mult4_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module mult4_rr_pick
  import mult4_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid  = 1'b1;
        grant_idx  = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult4_share_ctrl.sv
// Round-robin arbiter time-sharing one Multi4 among NREQ requesters over valid/ready.
module mult4_share_ctrl
  import mult4_share_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int CNTW = 16,
  localparam int IDW  = calc_idw(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PRODW-1:0]    rsp_prod,
  output logic [IDW-1:0]      rsp_id,
  output logic [CNTW-1:0]     ops_done,
  output logic                busy
);

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_valid;
  logic             accept;
  logic             rsp_fire;
  logic [OPW-1:0]   op_a, op_b;
  logic [IDW-1:0]   id_q;
  logic [PRODW-1:0] mul_p;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == '1) ? v : v + CNTW'(1);
  endfunction

  mult4_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = grant;
        if (any_valid) begin
          accept   = 1'b1;
          state_nx = MUL;
        end
      end
      MUL:  state_nx = RESP;
      RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Accept stage: operands and requester tag captured at the handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= req_a[grant_idx*OPW +: OPW];
      op_b <= req_b[grant_idx*OPW +: OPW];
      id_q <= grant_idx;
    end
  end

  Multi4 u_mul (
    .a0 (op_a[0]), .a1 (op_a[1]), .a2 (op_a[2]), .a3 (op_a[3]),
    .b0 (op_b[0]), .b1 (op_b[1]), .b2 (op_b[2]), .b3 (op_b[3]),
    .m0 (mul_p[0]), .m1 (mul_p[1]), .m2 (mul_p[2]), .m3 (mul_p[3]),
    .m4 (mul_p[4]), .m5 (mul_p[5]), .m6 (mul_p[6]), .m7 (mul_p[7])
  );

  // Response stage: product registered straight from Multi4, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
      ops_done  <= '0;
    end else if (state == MUL) begin
      rsp_prod  <= mul_p;
      rsp_id    <= id_q;
      rsp_valid <= 1'b1;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
      ops_done  <= sat_inc(ops_done);
    end
  end

endmodule
